// File: rtl/demux_rr_dispatch.sv
// Round-robin demultiplexer: steers each accepted upstream word into one of four
// per-channel holding registers, skipping disabled or still-full channels.
module demux_rr_dispatch #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [3:0]          ch_en,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic                sel0,
    output logic                sel1,
    output logic                grant_vld,
    output logic [15:0]         disp_cnt
);

    logic [3:0]             full_q, full_d;
    logic [3:0][DATA_W-1:0] data_q, data_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [3:0] eligible;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       found;

    // Eligibility uses start-of-cycle full flags only, so a same-cycle drain
    // never opens a channel for the word arriving in that cycle.
    assign eligible = ch_en & ~full_q;
    assign in_ready = |eligible;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        grant_idx = ptr_q;
        found     = 1'b0;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_vld = in_valid & in_ready;
    assign {sel1, sel0} = in_ready ? grant_idx : ptr_q;

    always_comb begin
        full_d = full_q & ~(full_q & out_ready);
        data_d = data_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (grant_vld) begin
            full_d[grant_idx] = 1'b1;
            data_d[grant_idx] = in_data;
            ptr_d             = grant_idx + 2'd1;
            cnt_d             = cnt_q + 16'd1;
        end
    end

    // NOTE: holding registers are reset too, because out_data must read zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            data_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            full_q <= full_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign disp_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch: hand-computed grants, fills, drains,
// reset behaviour and dispatch-counter wrap.
module tb_demux_rr_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  ch_en;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        sel0;
    logic        sel1;
    logic        grant_vld;
    logic [15:0] disp_cnt;

    int total = 0;
    int bad   = 0;

    demux_rr_dispatch #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel0      (sel0),
        .sel1      (sel1),
        .grant_vld (grant_vld),
        .disp_cnt  (disp_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ch_en     = 4'b1111;
        out_ready = 4'b0000;

        // Reset state, checked before any clock edge and again after one.
        #2;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out_data", out_data, 32'h0);
        check("rst_disp_cnt", disp_cnt, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sel", {sel1, sel0}, 2'd0);
        check("rst_grant_vld", grant_vld, 1'b0);
        tick();
        check("rst_hold_valid", out_valid, 4'b0000);
        rst = 1'b0;

        // Full rotation with free-flowing consumers: grants 0,1,2,3,0.
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1;
            check("rot_sel", {sel1, sel0}, 64'(i % 4));
            check("rot_grant_vld", grant_vld, 1'b1);
            tick();
            check("rot_out_valid", out_valid, 64'(4'b0001 << (i % 4)));
        end
        check("rot_disp_cnt", disp_cnt, 16'd5);
        check("rot_out_data", out_data, 32'hA3A2A1A4);
        in_valid = 1'b0;
        tick();
        check("rot_drained", out_valid, 4'b0000);

        // Back-pressure: fill all four, stall, drain ch2 only, refill ch2.
        pulse_reset();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            #1;
            check("fill_sel", {sel1, sel0}, 64'(i));
            check("fill_in_ready", in_ready, 1'b1);
            tick();
        end
        check("fill_out_valid", out_valid, 4'b1111);
        check("fill_disp_cnt", disp_cnt, 16'd4);
        in_data = 8'hB4;
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_grant_vld", grant_vld, 1'b0);
        check("stall_sel_ptr", {sel1, sel0}, 2'd0);
        tick();
        check("stall_disp_cnt", disp_cnt, 16'd4);
        check("stall_out_data", out_data, 32'hB3B2B1B0);
        in_valid  = 1'b0;
        out_ready = 4'b0100;
        #1;
        check("drain_no_same_cycle", in_ready, 1'b0);
        tick();
        check("drain_ch2", out_valid, 4'b1011);
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'hB5;
        #1;
        check("refill_sel", {sel1, sel0}, 2'd2);
        check("refill_grant_vld", grant_vld, 1'b1);
        tick();
        check("refill_out_valid", out_valid, 4'b1111);
        check("refill_data", out_data[23:16], 8'hB5);
        check("refill_disp_cnt", disp_cnt, 16'd5);

        // Sparse enable: only channels 1 and 3 may be granted.
        pulse_reset();
        ch_en     = 4'b1010;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            #1;
            check("sparse_sel", {sel1, sel0}, (i % 2 == 0) ? 64'd1 : 64'd3);
            tick();
            check("sparse_unused_idle", out_valid & 4'b0101, 4'b0000);
        end
        check("sparse_out_data", out_data, 32'hC300C200);

        // Disabling a full channel keeps its word; it drains and is never granted again.
        pulse_reset();
        ch_en     = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hD0 + 8'(i);
            tick();
        end
        in_valid  = 1'b0;
        ch_en     = 4'b1011;
        out_ready = 4'b0100;
        #1;
        check("dis_still_full", out_valid, 4'b0111);
        tick();
        check("dis_drained", out_valid, 4'b0011);
        check("dis_data_kept", out_data[23:16], 8'hD2);
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'hE0;
        #1;
        check("dis_grant_ch3", {sel1, sel0}, 2'd3);
        tick();
        check("dis_after_ch3", out_valid, 4'b1011);
        #1;
        check("dis_stall_in_ready", in_ready, 1'b0);
        check("dis_stall_sel_ptr", {sel1, sel0}, 2'd0);
        tick();
        check("dis_ch2_never", out_valid, 4'b1011);
        check("dis_disp_cnt", disp_cnt, 16'd4);

        // Short reset pulse between edges discards held words at once.
        pulse_reset();
        ch_en     = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hF0 + 8'(i);
            tick();
        end
        check("mid_before_valid", out_valid, 4'b0111);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 4'b0000);
        check("mid_rst_disp_cnt", disp_cnt, 16'd0);
        check("mid_rst_data", out_data, 32'h0);
        rst     = 1'b0;
        in_data = 8'h5A;
        #1;
        check("mid_first_sel", {sel1, sel0}, 2'd0);
        tick();
        check("mid_first_valid", out_valid, 4'b0001);
        check("mid_first_data", out_data[7:0], 8'h5A);
        check("mid_first_cnt", disp_cnt, 16'd1);

        // Counter wrap after 65536 accepts.
        pulse_reset();
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("wrap_pre", disp_cnt, 16'hFFFF);
        check("wrap_in_ready", in_ready, 1'b1);
        tick();
        check("wrap_zero", disp_cnt, 16'h0000);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_dispatch.md
DEMUX_RR_DISPATCH -- requirements
Module: demux_rr_dispatch

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_data  input  DATA_W  upstream word.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 ch_en  input  4  per-channel enable; bit k=0 excludes channel k from grants.
REQ-008 out_valid  output  4  bit k: channel k holding register full.
REQ-009 out_ready  input  4  bit k: channel k consumer takes word this cycle.
REQ-010 out_data  output  4*DATA_W  channel k word on bits [k*DATA_W +: DATA_W].
REQ-011 sel0  output  1  LSB of channel index granted this cycle.
REQ-012 sel1  output  1  MSB of channel index granted this cycle.
REQ-013 grant_vld  output  1  a word is accepted this cycle (in_valid and in_ready).
REQ-014 disp_cnt  output  16  count of accepted words since reset.

Function
REQ-015 Each channel k SHALL own one DATA_W holding register plus a full flag driving out_valid[k].
REQ-016 Channel k is eligible when ch_en[k]=1 and out_valid[k]=0 at the start of the cycle; same-cycle drain SHALL NOT make a channel eligible.
REQ-017 in_ready SHALL be 1 exactly when at least one channel is eligible, combinational from registered state and ch_en, independent of in_valid.
REQ-018 Grant SHALL be the first eligible channel searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), where ptr is a 2-bit round-robin pointer.
REQ-019 {sel1,sel0} SHALL equal the granted index when in_ready=1, else hold ptr.
REQ-020 On accept (in_valid & in_ready): in_data written to granted register, its out_valid set next edge, ptr <= granted index + 1 mod 4 (3 wraps to 0), disp_cnt increments.
REQ-021 No accept: ptr and disp_cnt SHALL hold.
REQ-022 Channel k drains when out_valid[k] & out_ready[k]; out_valid[k] clears next edge; out_data holds last value (not cleared).
REQ-023 Latency in_data accept to out_valid[k]=1 SHALL be exactly 1 cycle; a word SHALL be written to exactly one channel.
REQ-024 Accept to channel k and drain of channel k cannot coincide (REQ-016); drain of k with accept to j≠k in the same cycle SHALL both take effect.
REQ-025 Clearing ch_en[k] while out_valid[k]=1 SHALL NOT discard the word; it still drains normally.
REQ-026 ch_en=4'b0000 or all enabled channels full: in_ready=0, upstream stalls, no state change except drains.
REQ-027 disp_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 out_ready[k] while out_valid[k]=0 SHALL have no effect.

Reset
REQ-029 While rst=1: out_valid=4'b0000, out_data all zeros, ptr=0, disp_cnt=0, regardless of clk.
REQ-030 rst asserted mid-operation SHALL discard all held words immediately; first accept after release goes to lowest-index eligible channel from 0.
REQ-031 in_ready, sel0, sel1, grant_vld SHALL follow REQ-017/019 from reset state (in_ready=1 if any ch_en bit set).

Verification
REQ-032 Reset, ch_en=1111, out_ready=1111, in_valid=1 with data 0xA0,0xA1,0xA2,0xA3,0xA4 on 5 cycles -> grants to channels 0,1,2,3,0; {sel1,sel0}=00,01,10,11,00; disp_cnt=5.
REQ-033 ch_en=1111, out_ready=0000, 5 words offered -> first 4 accepted to ch0..3, in_ready=0 on cycle 5, out_valid=1111; then out_ready=0100 one cycle -> ch2 drains, next word goes to ch2.
REQ-034 ch_en=1010, out_ready=1111, 4 words -> grants alternate 1,3,1,3; channels 0 and 2 never out_valid.
REQ-035 ch2 full, ch_en[2] cleared, out_ready[2]=1 -> out_valid[2] falls next edge with original data intact; ch2 never granted afterward.
REQ-036 3 words held, rst pulsed for 1 ns between edges -> out_valid=0000, disp_cnt=0 immediately; next word grants ch0.
REQ-037 Preload disp_cnt to 16'hFFFF via 65535 accepts, one more accept -> disp_cnt=16'h0000.
